// File: rtl/disp_ctrl_if.sv
// Message handshake between a requester and the display controller.
//   msg_req    : request, held high by the requester until msg_ack
//   msg_word   : message value, sampled when the request is accepted
//   msg_active : high while the message is on the display
//   msg_ack    : one-clk pulse at the end of the message hold
// master = requester side, slave = disp_ctrl side.
interface disp_ctrl_if;
  logic        msg_req;
  logic [15:0] msg_word;
  logic        msg_active;
  logic        msg_ack;

  modport master (
    output msg_req,
    output msg_word,
    input  msg_active,
    input  msg_ack
  );

  modport slave (
    input  msg_req,
    input  msg_word,
    output msg_active,
    output msg_ack
  );
endinterface

// File: rtl/disp_ctrl.sv
// Display controller for a 4-digit 7-segment driver.
// Generates the digit-scan strobe and picks the 16-bit word to show: one of four
// datapath sources (cycled by a debounced push-button) or a timed message that
// temporarily overrides the selected source.
// Ports:
//   clk, reset  : system clock, synchronous active-high reset
//   i_src_words : four source words, source k = i_src_words[16k+15:16k]
//   i_sel_btn   : raw asynchronous push-button, active-high
//   msg_if      : message handshake (slave side)
//   o_scan_en   : one-clk strobe every PRESCALE clks
//   o_word      : registered word to display
//   o_src_sel   : current source index
module disp_ctrl #(
  parameter int unsigned PRESCALE       = 50000,
  parameter int unsigned HOLD_SCANS     = 1024,
  parameter int unsigned DEBOUNCE_SCANS = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] i_src_words,
  input  logic        i_sel_btn,
  disp_ctrl_if.slave  msg_if,
  output logic        o_scan_en,
  output logic [15:0] o_word,
  output logic [1:0]  o_src_sel
);

  localparam int unsigned PW = $clog2(PRESCALE);
  localparam int unsigned HW = $clog2(HOLD_SCANS + 1);
  localparam int unsigned DW = $clog2(DEBOUNCE_SCANS + 1);

  localparam logic [PW-1:0] PresMax = PW'(PRESCALE - 1);
  localparam logic [HW-1:0] HoldMax = HW'(HOLD_SCANS - 1);
  localparam logic [DW-1:0] DebCnt  = DW'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {StNormal, StShow, StAck, StRelease} state_e;

  state_e          r_state, w_state_next;
  logic [PW-1:0]   r_presc;
  logic            r_scan_en;
  logic            r_sync1, r_sync2;
  logic            r_db;
  logic [DW-1:0]   r_db_cnt;
  logic [DW-1:0]   w_db_cnt_inc;
  logic [1:0]      r_src_sel;
  logic [HW-1:0]   r_hold;
  logic [15:0]     r_msg;
  logic [15:0]     r_word;
  logic [15:0]     w_src_word;

  // Scan prescaler; strobe is registered so the first pulse lands on edge PRESCALE.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_presc   <= '0;
      r_scan_en <= 1'b0;
    end else begin
      r_scan_en <= (r_presc == PresMax);
      r_presc   <= (r_presc == PresMax) ? '0 : r_presc + 1'b1;
    end
  end

  assign w_db_cnt_inc = r_db_cnt + 1'b1;

  // Button synchronizer, scan-rate debouncer and source select.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_db      <= 1'b0;
      r_db_cnt  <= '0;
      r_src_sel <= 2'd0;
    end else begin
      r_sync1 <= i_sel_btn;
      r_sync2 <= r_sync1;
      if (r_scan_en) begin
        if (r_sync2 != r_db) begin
          if (w_db_cnt_inc == DebCnt) begin
            r_db     <= ~r_db;
            r_db_cnt <= '0;
            // Only a press (0->1 of the debounced level) advances the source.
            if (!r_db) r_src_sel <= r_src_sel + 2'd1;
          end else begin
            r_db_cnt <= w_db_cnt_inc;
          end
        end else begin
          r_db_cnt <= '0;
        end
      end
    end
  end

  always_comb begin
    w_src_word = i_src_words[15:0];
    unique case (r_src_sel)
      2'd0: w_src_word = i_src_words[15:0];
      2'd1: w_src_word = i_src_words[31:16];
      2'd2: w_src_word = i_src_words[47:32];
      2'd3: w_src_word = i_src_words[63:48];
      default: w_src_word = i_src_words[15:0];
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= StNormal;
    else       r_state <= w_state_next;
  end

  // FSM next state.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StNormal:  if (msg_if.msg_req) w_state_next = StShow;
      StShow:    if (r_scan_en && (r_hold == HoldMax)) w_state_next = StAck;
      StAck:     w_state_next = StRelease;
      StRelease: if (!msg_if.msg_req) w_state_next = StNormal;
      default:   w_state_next = StNormal;
    endcase
  end

  // FSM outputs, decoded from the registered state.
  always_comb begin
    msg_if.msg_active = (r_state == StShow);
    msg_if.msg_ack    = (r_state == StAck);
  end

  // Display word, message latch and hold counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_word <= 16'd0;
      r_msg  <= 16'd0;
      r_hold <= '0;
    end else begin
      case (r_state)
        StNormal: begin
          if (msg_if.msg_req) begin
            r_msg  <= msg_if.msg_word;
            r_word <= msg_if.msg_word;
            r_hold <= '0;
          end else begin
            r_word <= w_src_word;
          end
        end
        StShow: begin
          r_word <= r_msg;
          if (r_scan_en) r_hold <= r_hold + 1'b1;
        end
        default: r_word <= w_src_word;
      endcase
    end
  end

  assign o_scan_en = r_scan_en;
  assign o_word    = r_word;
  assign o_src_sel = r_src_sel;

endmodule

// File: tb/tb_disp_ctrl.sv
// Bench for disp_ctrl with PRESCALE=4, HOLD_SCANS=3, DEBOUNCE_SCANS=2.
// A reference model advanced once per clock edge predicts every output; directed
// steps add fixed expectations, then a randomized run exercises button, sources,
// requester and occasional resets against the model.
module tb_disp_ctrl;
  localparam int P = 4;
  localparam int H = 3;
  localparam int D = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] src_words = '0;
  logic        sel_btn = 1'b0;
  logic        scan_en;
  logic [15:0] word;
  logic [1:0]  src_sel;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state.
  int          m_cnt = 0, m_dbc = 0, m_sel = 0, m_hold = 0, m_mode = 0; // mode: 0 normal,1 show,2 ack,3 release
  bit          m_scan = 0, m_s1 = 0, m_s2 = 0, m_db = 0;
  logic [15:0] m_word = '0, m_msg = '0;

  disp_ctrl_if mif();

  disp_ctrl #(
    .PRESCALE      (P),
    .HOLD_SCANS    (H),
    .DEBOUNCE_SCANS(D)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .i_src_words(src_words),
    .i_sel_btn  (sel_btn),
    .msg_if     (mif),
    .o_scan_en  (scan_en),
    .o_word     (word),
    .o_src_sel  (src_sel)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] src_of(input int k);
    return src_words[16*k +: 16];
  endfunction

  // One clock edge of the model, using the inputs the DUT sampled on that edge.
  task automatic model_step();
    bit old_scan;
    int old_sel;
    if (reset) begin
      m_cnt = 0; m_dbc = 0; m_sel = 0; m_hold = 0; m_mode = 0;
      m_scan = 0; m_s1 = 0; m_s2 = 0; m_db = 0; m_word = '0; m_msg = '0;
    end else begin
      old_scan = m_scan;
      old_sel  = m_sel;
      m_scan = (m_cnt == P - 1);
      m_cnt  = (m_cnt + 1) % P;
      case (m_mode)
        0: if (mif.msg_req) begin
             m_msg = mif.msg_word; m_word = mif.msg_word; m_hold = 0; m_mode = 1;
           end else m_word = src_of(old_sel);
        1: begin
             m_word = m_msg;
             if (old_scan) begin
               if (m_hold == H - 1) m_mode = 2;
               m_hold++;
             end
           end
        2: begin m_word = src_of(old_sel); m_mode = 3; end
        default: begin m_word = src_of(old_sel); if (!mif.msg_req) m_mode = 0; end
      endcase
      if (old_scan) begin
        if (m_s2 != m_db) begin
          m_dbc++;
          if (m_dbc == D) begin
            m_db  = !m_db;
            m_dbc = 0;
            if (m_db) m_sel = (m_sel + 1) % 4;
          end
        end else m_dbc = 0;
      end
      m_s2 = m_s1;
      m_s1 = sel_btn;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    chk("scan_en", {31'd0, scan_en}, {31'd0, m_scan});
    chk("word", {16'd0, word}, {16'd0, m_word});
    chk("src_sel", {30'd0, src_sel}, 32'(m_sel));
    chk("msg_active", {31'd0, mif.msg_active}, {31'd0, m_mode == 1});
    chk("msg_ack", {31'd0, mif.msg_ack}, {31'd0, m_mode == 2});
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_model();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic press();
    sel_btn = 1'b1;
    ticks(12);
    sel_btn = 1'b0;
    ticks(12);
  endtask

  initial begin
    int strobes;
    bit seen_ack;
    bit saw_adv;
    int acks;
    int idx;
    bit got_ack;

    mif.msg_req  = 1'b0;
    mif.msg_word = 16'd0;
    src_words    = {16'hDDDD, 16'hCCCC, 16'hBBBB, 16'hAAAA};
    reset        = 1'b1;
    @(negedge clk);
    ticks(2);
    chk("rst_word", {16'd0, word}, 32'd0);
    chk("rst_scan", {31'd0, scan_en}, 32'd0);
    chk("rst_sel", {30'd0, src_sel}, 32'd0);
    chk("rst_active", {31'd0, mif.msg_active}, 32'd0);
    chk("rst_ack", {31'd0, mif.msg_ack}, 32'd0);
    reset = 1'b0;

    // Scan strobe phase after release, and word one clk after release.
    for (int i = 1; i <= 12; i++) begin
      tick();
      chk("scan_phase", {31'd0, scan_en}, {31'd0, (i % 4) == 0});
      if (i == 1) chk("word_after_rst", {16'd0, word}, 32'h0000AAAA);
    end
    ticks(2);
    reset = 1'b1;
    tick();
    chk("scan_in_rst", {31'd0, scan_en}, 32'd0);
    reset = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("scan_restart", {31'd0, scan_en}, {31'd0, i == 4});
    end

    // Source word follows with one clk latency.
    src_words[15:0] = 16'h1234;
    tick();
    chk("word_src0", {16'd0, word}, 32'h00001234);

    // Button: full press, glitch, and wrap over four presses.
    press();
    chk("sel_after_press", {30'd0, src_sel}, 32'd1);
    chk("word_sel1", {16'd0, word}, 32'h0000BBBB);
    sel_btn = 1'b1;
    ticks(4);
    sel_btn = 1'b0;
    ticks(12);
    chk("sel_glitch", {30'd0, src_sel}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      press();
      chk("sel_wrap", {30'd0, src_sel}, 32'(k % 4));
    end

    // Message display, hold length, ack and no retrigger.
    mif.msg_word = 16'hBEEF;
    mif.msg_req  = 1'b1;
    tick();
    chk("msg_active_on", {31'd0, mif.msg_active}, 32'd1);
    chk("msg_word_show", {16'd0, word}, 32'h0000BEEF);
    mif.msg_word = 16'h1111;
    strobes  = 0;
    seen_ack = 1'b0;
    for (int i = 0; i < 60 && !seen_ack; i++) begin
      if (mif.msg_active) begin
        chk("word_hold", {16'd0, word}, 32'h0000BEEF);
        if (scan_en) strobes++;
      end
      tick();
      if (mif.msg_ack) seen_ack = 1'b1;
    end
    chk("ack_seen", {31'd0, seen_ack}, 32'd1);
    chk("hold_strobes", 32'(strobes), 32'(H));
    tick();
    chk("ack_width", {31'd0, mif.msg_ack}, 32'd0);
    chk("word_back", {16'd0, word}, 32'h00001234);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("no_retrigger", {31'd0, mif.msg_active}, 32'd0);
    end
    mif.msg_req = 1'b0;
    tick();

    // Button press during a message.
    sel_btn = 1'b1;
    ticks(6);
    mif.msg_word = 16'hBEEF;
    mif.msg_req  = 1'b1;
    tick();
    seen_ack = 1'b0;
    saw_adv  = 1'b0;
    for (int i = 0; i < 60 && !seen_ack; i++) begin
      if (mif.msg_active) begin
        chk("word_hold_btn", {16'd0, word}, 32'h0000BEEF);
        if (src_sel == 2'd1) saw_adv = 1'b1;
      end
      tick();
      if (mif.msg_ack) seen_ack = 1'b1;
    end
    chk("ack_seen_btn", {31'd0, seen_ack}, 32'd1);
    chk("sel_adv_in_show", {31'd0, saw_adv}, 32'd1);
    sel_btn = 1'b0;
    tick();
    chk("word_new_src", {16'd0, word}, 32'h0000BBBB);
    mif.msg_req = 1'b0;
    ticks(12);

    // Reset during SHOW aborts without ack.
    mif.msg_word = 16'hCAFE;
    mif.msg_req  = 1'b1;
    ticks(3);
    chk("show_before_rst", {31'd0, mif.msg_active}, 32'd1);
    reset       = 1'b1;
    mif.msg_req = 1'b0;
    tick();
    chk("abort_active", {31'd0, mif.msg_active}, 32'd0);
    chk("abort_word", {16'd0, word}, 32'd0);
    chk("abort_sel", {30'd0, src_sel}, 32'd0);
    reset = 1'b0;
    acks  = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (mif.msg_ack) acks++;
    end
    chk("no_ack_after_abort", 32'(acks), 32'd0);

    // Randomized run against the model.
    got_ack = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 15) == 0) sel_btn = ~sel_btn;
      if ($urandom_range(0, 7) == 0) begin
        idx = $urandom_range(0, 3);
        src_words[16*idx +: 16] = 16'($urandom);
      end
      if (!mif.msg_req && $urandom_range(0, 19) == 0) begin
        mif.msg_req  = 1'b1;
        mif.msg_word = 16'($urandom);
        got_ack      = 1'b0;
      end else if (mif.msg_req && got_ack && $urandom_range(0, 2) == 0) begin
        mif.msg_req = 1'b0;
      end else if ($urandom_range(0, 3) == 0) begin
        mif.msg_word = 16'($urandom);
      end
      reset = ($urandom_range(0, 249) == 0);
      tick();
      if (mif.msg_ack || reset) got_ack = 1'b1;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/disp_ctrl.md
Name: disp_ctrl

Overview:
Controller for the 4-digit 7-segment display driver. It generates the digit-scan clock enable and selects which 16-bit word the driver shows. The word comes either from one of four datapath sources (e.g. PC, A, B, bus), cycled by a debounced push-button, or from a timed, handshaked message request that temporarily overrides the selected source. Sits between the CPU datapath and the display driver at board top level.

Parameters:
PRESCALE, 50000, clk cycles per scan strobe; legal range >=2
HOLD_SCANS, 1024, scan strobes a message is held on the display; legal range >=1
DEBOUNCE_SCANS, 8, consecutive scan strobes sel_btn must differ from the debounced level before the debounced level changes; legal range >=1

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
src_words  in  64  four source words; source k = src_words[16k+15:16k]
sel_btn  in  1  raw asynchronous push-button, active-high
msg_req  in  1  message request; held high until msg_ack
msg_word  in  16  message value, sampled when a request is accepted
scan_en  out  1  one-clk strobe, once per PRESCALE clks; drives the driver's clken
word  out  16  registered word to display
src_sel  out  2  current source index
msg_active  out  1  high while a message is displayed
msg_ack  out  1  one-clk pulse at the end of the message hold

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high; all state is cleared on a clk edge with reset=1.
- Reset values: scan_en=0, word=0, src_sel=0, msg_active=0, msg_ack=0. The prescaler, hold counter, debounce counter and debounced level are 0, the sync flops are 0, and the FSM is in NORMAL.
- Reset mid-message: the message is aborted, no msg_ack is issued, and all state returns to its reset values.
- Prescaler:
  - Counts 0..PRESCALE-1 and wraps.
  - scan_en is registered and is high for exactly one clk per PRESCALE clks.
  - The first pulse comes on the PRESCALE-th rising edge after reset deasserts, then every PRESCALE clks after that.
- Button path:
  - sel_btn passes through a 2-flop synchronizer.
  - The debouncer acts only on scan_en cycles. If the synced level differs from the debounced level, the counter increments; otherwise it clears.
  - When the counter reaches DEBOUNCE_SCANS, the debounced level flips and the counter clears.
- Source select:
  - A 0->1 transition of the debounced level increments src_sel mod 4 (3 wraps to 0).
  - src_sel advances in every FSM state, including during a message.
- FSM states are NORMAL, SHOW, ACK and RELEASE.
  - NORMAL:
    - word <= selected source word every clk, i.e. 1-clk latency from src_words/src_sel to word.
    - If msg_req=1: latch msg_word, clear the hold counter, set msg_active=1 and go to SHOW. The message appears on word on the following clk.
  - SHOW:
    - word <= latched message. Changes on msg_word and msg_req are ignored.
    - The hold counter increments on each scan_en.
    - On the scan_en where the hold counter equals HOLD_SCANS-1: go to ACK and drop msg_active. The message is therefore held for exactly HOLD_SCANS strobes counted from the first scan_en after entry.
  - ACK:
    - msg_ack=1 for this single clk.
    - word <= selected source word.
    - Go to RELEASE.
  - RELEASE:
    - word <= selected source word.
    - Stay until msg_req=0, then go to NORMAL. A request left high never retriggers.
- Simultaneous events: a button edge and message acceptance in the same clk are both performed.
- scan_en is unaffected by FSM state.

Test Plan:
(Bench parameters: PRESCALE=4, HOLD_SCANS=3, DEBOUNCE_SCANS=2.)
1. Reset, then release -> all outputs 0. scan_en pulses on edges 4, 8, 12 after release, each pulse 1 clk wide. Assert reset mid-count -> counter restarts and the next pulse is 4 clks after release.
2. src_words = {16'hDDDD,16'hCCCC,16'hBBBB,16'hAAAA} -> word=16'hAAAA one clk after reset release. Change source 0 to 16'h1234 -> word=16'h1234 one clk later.
3. Hold sel_btn high for 3 strobes -> src_sel=1 and word=16'hBBBB. A 1-strobe glitch -> no change. Four full presses from src_sel=0 -> src_sel wraps back to 0.
4. Pulse msg_req with msg_word=16'hBEEF -> msg_active=1 and word=16'hBEEF next clk, held for 3 scan strobes. Then msg_ack pulses 1 clk and word returns to the selected source. Keep msg_req high 20 more clks -> no second message.
5. Press sel_btn during a message -> src_sel advances while word stays 16'hBEEF. After msg_ack, word shows the new source.
6. Assert reset during SHOW -> msg_active=0, msg_ack never pulses, word=0, src_sel=0.
